// File: rtl/avcompare_pkg.sv
// Shared types and helpers for the AVC vector comparator.
package avcompare_pkg;

  // Comparator sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // FIFO record: {vec_num, vec_exp, vec_rcv, mis}.
  function automatic int unsigned rec_width(input int unsigned nsig, input int unsigned vecw);
    return 3 * nsig + vecw;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= m) ? m : v + 64'd1;
  endfunction

endpackage

// File: rtl/avcmp_sfifo.sv
// Single-clock FIFO with a registered show-ahead head. A pushed entry becomes
// visible on q one edge after the write, so empty deasserts at push edge + 1.
module avcmp_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             ureset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] q
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             qv_q;
  logic [WIDTH-1:0] q_q;
  logic             do_push, do_pop;

  // Fullness is judged on the pre-edge count, so a same-cycle pop frees nothing.
  always_comb begin
    do_push = push & (cnt_q != (AW+1)'(DEPTH));
    do_pop  = pop & qv_q;
    rptr_d  = rptr_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  // Pointers, occupancy and the registered head. Only entries already written
  // before this edge may become visible, which gives the one-cycle lag.
  always_ff @(posedge clk) begin
    if (ureset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      qv_q   <= 1'b0;
      q_q    <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      qv_q   <= (cnt_q - (AW+1)'(do_pop)) != '0;
      q_q    <= mem_q[rptr_d];
    end
  end

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = ~qv_q;
  assign q     = q_q;

endmodule

// File: rtl/avcompare_par.sv
// AVC vector comparator: masks each received vector against the expected one,
// queues mismatching vectors and expands them bit by bit into error records.
module avcompare_par
  import avcompare_pkg::*;
#(
  parameter int unsigned         NSIG     = 16,
  parameter int unsigned         VECW     = 32,
  parameter int unsigned         DEPTH    = 16,
  parameter int unsigned         NAMEW    = 8,
  parameter logic [NAMEW-1:0]    NAMEBASE = 8'h0F
) (
  input  logic             clk,
  input  logic             ureset,
  input  logic             vec_valid,
  input  logic [VECW-1:0]  vec_num,
  input  logic [NSIG-1:0]  vec_exp,
  input  logic [NSIG-1:0]  vec_rcv,
  input  logic [NSIG-1:0]  vec_hlmsk,
  input  logic [NSIG-1:0]  vec_dir,
  input  logic             vec_last,
  input  logic [VECW-1:0]  max_err,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [VECW-1:0]  err_vec,
  output logic [NAMEW-1:0] err_sig,
  output logic             err_exp,
  output logic             err_rcv,
  output logic [VECW-1:0]  err_cnt,
  output logic [VECW-1:0]  drop_cnt,
  output logic             ovf,
  output logic             cmpdone
);

  localparam int unsigned RecW = rec_width(NSIG, VECW);
  localparam int unsigned IW   = (NSIG > 1) ? $clog2(NSIG) : 1;

  logic [NSIG-1:0] mis;
  logic            mism, push, pop, load;
  logic            full, empty;
  logic [RecW-1:0] fifo_din, fifo_q;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VECW-1:0] vnp1_q;
  logic [NSIG-1:0] exp_r_q, rcv_r_q, mis_r_q;
  logic [VECW-1:0] err_cnt_q, err_cnt_d, drop_cnt_q;
  logic            ovf_q, last_seen_q, push_q;
  logic            limit_hit, cur_mis;

  // Compare stage: only checked, output-direction bits can mismatch.
  always_comb begin
    mis      = (vec_rcv ^ vec_exp) & vec_hlmsk & vec_dir;
    mism     = vec_valid & (mis != '0);
    push     = mism & ~full;
    fifo_din = {vec_num, vec_exp, vec_rcv, mis};
  end

  avcmp_sfifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .ureset (ureset),
    .push   (push),
    .din    (fifo_din),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .q      (fifo_q)
  );

  assign limit_hit = (max_err != '0) && (err_cnt_q >= max_err);
  assign cur_mis   = mis_r_q[idx_q];

  // Sequencer next state, record expansion and handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    pop       = 1'b0;
    load      = 1'b0;
    err_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !limit_hit) begin
          pop     = 1'b1;
          load    = 1'b1;
          idx_d   = '0;
          state_d = StScan;
        end else if (last_seen_q && ((empty && !push_q) || limit_hit)) begin
          // push_q covers a vector written last edge but not yet visible.
          state_d = StDone;
        end
      end
      StScan: begin
        err_valid = cur_mis & ~limit_hit;
        if (limit_hit) begin
          state_d = StIdle;
        end else if (!cur_mis || err_ready) begin
          if (cur_mis) err_cnt_d = VECW'(sat_inc(64'(err_cnt_q), VECW));
          if ((idx_q == IW'(NSIG - 1)) ||
              (cur_mis && (max_err != '0) && (err_cnt_d >= max_err))) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, scan index, record register and accepted-record counter.
  always_ff @(posedge clk) begin
    if (ureset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      err_cnt_q <= '0;
      vnp1_q    <= '0;
      exp_r_q   <= '0;
      rcv_r_q   <= '0;
      mis_r_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
      if (load) begin
        vnp1_q  <= fifo_q[RecW-1 -: VECW] + VECW'(1);
        exp_r_q <= fifo_q[3*NSIG-1 -: NSIG];
        rcv_r_q <= fifo_q[2*NSIG-1 -: NSIG];
        mis_r_q <= fifo_q[NSIG-1:0];
      end
    end
  end

  // Drop accounting and end-of-file tracking.
  always_ff @(posedge clk) begin
    if (ureset) begin
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      last_seen_q <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      if (mism && full) begin
        drop_cnt_q <= VECW'(sat_inc(64'(drop_cnt_q), VECW));
        ovf_q      <= 1'b1;
      end
      if (vec_valid && vec_last) last_seen_q <= 1'b1;
      push_q <= push;
    end
  end

  assign err_vec  = vnp1_q;
  assign err_sig  = NAMEW'(32'(NAMEBASE) + 32'(idx_q));
  assign err_exp  = exp_r_q[idx_q];
  assign err_rcv  = rcv_r_q[idx_q];
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign ovf      = ovf_q;
  assign cmpdone  = (state_q == StDone);

endmodule

// File: tb/tb_avcompare_par.sv
// Scoreboard bench for avcompare_par: stimulus pushes expected records, a
// monitor pops and compares on every accepted record.
module tb_avcompare_par;

  localparam int unsigned NSIG = 16;
  localparam int unsigned VECW = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk, ureset, vec_valid, vec_last, err_ready;
  logic [31:0] vec_num, max_err;
  logic [15:0] vec_exp, vec_rcv, vec_hlmsk, vec_dir;
  logic        err_valid, err_exp, err_rcv, ovf, cmpdone;
  logic [31:0] err_vec, err_cnt, drop_cnt;
  logic [7:0]  err_sig;

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  s;
    logic        e;
    logic        r;
  } rec_t;

  rec_t        sb[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned mdl_cnt = 0;
  int unsigned mdl_lim = 0;
  int unsigned mdl_drop = 0;
  bit          rnd_ready = 0;

  avcompare_par #(
    .NSIG     (NSIG),
    .VECW     (VECW),
    .DEPTH    (DEPTH),
    .NAMEW    (8),
    .NAMEBASE (8'h0F)
  ) dut (
    .clk       (clk),
    .ureset    (ureset),
    .vec_valid (vec_valid),
    .vec_num   (vec_num),
    .vec_exp   (vec_exp),
    .vec_rcv   (vec_rcv),
    .vec_hlmsk (vec_hlmsk),
    .vec_dir   (vec_dir),
    .vec_last  (vec_last),
    .max_err   (max_err),
    .err_valid (err_valid),
    .err_ready (err_ready),
    .err_vec   (err_vec),
    .err_sig   (err_sig),
    .err_exp   (err_exp),
    .err_rcv   (err_rcv),
    .err_cnt   (err_cnt),
    .drop_cnt  (drop_cnt),
    .ovf       (ovf),
    .cmpdone   (cmpdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: every checked, output-direction bit that differs is one record.
  task automatic send_vec(input logic [31:0] num, input logic [15:0] e, input logic [15:0] r,
                          input logic [15:0] hl, input logic [15:0] d, input bit last,
                          input bit store);
    rec_t t;
    bit   any;
    @(negedge clk);
    vec_valid = 1'b1;
    vec_num   = num;
    vec_exp   = e;
    vec_rcv   = r;
    vec_hlmsk = hl;
    vec_dir   = d;
    vec_last  = last;
    any = 1'b0;
    for (int i = 0; i < int'(NSIG); i++) begin
      if (hl[i] && d[i] && (e[i] != r[i])) begin
        any = 1'b1;
        if (store && (mdl_lim == 0 || mdl_cnt < mdl_lim)) begin
          t.v = num + 32'd1;
          t.s = 8'(8'h0F + i);
          t.e = e[i];
          t.r = r[i];
          sb.push_back(t);
          mdl_cnt++;
        end
      end
    end
    if (any && !store) mdl_drop++;
  endtask

  task automatic idle();
    @(negedge clk);
    vec_valid = 1'b0;
    vec_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ureset    = 1'b1;
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    @(negedge clk);
    ureset = 1'b0;
    sb.delete();
    mdl_cnt  = 0;
    mdl_drop = 0;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d records pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (NSIG + 4) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (!err_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    n_tests++;
    if (!err_valid) begin
      n_fail++;
      $display("FAIL %s: err_valid=0 after 100 cycles, expected 1", name);
    end
  endtask

  // Monitor: sampled mid-cycle, consumes one expected record per handshake.
  always begin
    rec_t x;
    @(negedge clk);
    #4;
    if (!ureset && err_valid && err_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: got vec=%0h sig=%0h, expected no record",
                 err_vec, err_sig);
      end else begin
        x = sb.pop_front();
        check("rec_vec", 64'(err_vec), 64'(x.v));
        check("rec_sig", 64'(err_sig), 64'(x.s));
        check("rec_exp", 64'(err_exp), 64'(x.e));
        check("rec_rcv", 64'(err_rcv), 64'(x.r));
      end
    end
  end

  always @(negedge clk) begin
    if (rnd_ready) err_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [15:0] re, rr, rh, rd;
    int          n;
    ureset    = 1'b1;
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    vec_num   = '0;
    vec_exp   = '0;
    vec_rcv   = '0;
    vec_hlmsk = '0;
    vec_dir   = '0;
    max_err   = '0;
    err_ready = 1'b1;
    do_reset();

    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_vec", 64'(err_vec), 64'd0);
    check("rst_err_sig", 64'(err_sig), 64'h0F);
    check("rst_err_exp", 64'(err_exp), 64'd0);
    check("rst_err_rcv", 64'(err_rcv), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_cmpdone", 64'(cmpdone), 64'd0);

    // Single mismatch on bit 2 of vector 5.
    send_vec(32'd5, 16'h00FF, 16'h00FB, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    idle();
    drain();
    check("single_err_cnt", 64'(err_cnt), 64'd1);

    // Same vector with the mismatching pin as input: no record, then last.
    do_reset();
    send_vec(32'd5, 16'h00FF, 16'h00FB, 16'hFFFF, 16'hFFFB, 1'b0, 1'b1);
    idle();
    repeat (NSIG + 6) @(negedge clk);
    check("dirmask_err_cnt", 64'(err_cnt), 64'd0);
    send_vec(32'd6, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("cmpdone_early", 64'(cmpdone), 64'd0);
    idle();
    @(posedge clk);
    #1;
    check("cmpdone_rise", 64'(cmpdone), 64'd1);

    // Back-pressure: bits 0, 7, 15 with the sink stalled for 10 cycles.
    do_reset();
    err_ready = 1'b0;
    send_vec(32'h10, 16'h8081, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    idle();
    wait_valid("stall_valid");
    for (int c = 0; c < 10; c++) begin
      check("stall_hold_valid", 64'(err_valid), 64'd1);
      check("stall_hold_sig", 64'(err_sig), 64'h0F);
      check("stall_hold_vec", 64'(err_vec), 64'h11);
      check("stall_hold_exp", 64'(err_exp), 64'd1);
      check("stall_hold_rcv", 64'(err_rcv), 64'd0);
      @(negedge clk);
    end
    err_ready = 1'b1;
    drain();

    // Random bursts short enough that the FIFO never overflows.
    rnd_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        re = 16'($urandom);
        rr = ($urandom_range(0, 3) == 0) ? re : (re ^ 16'($urandom & $urandom));
        rh = 16'($urandom | $urandom);
        rd = 16'($urandom | $urandom);
        send_vec($urandom, re, rr, rh, rd, 1'b0, 1'b1);
      end
      idle();
      drain();
    end
    rnd_ready = 1'b0;
    @(negedge clk);
    err_ready = 1'b1;
    check("rand_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rand_ovf", 64'(ovf), 64'd0);
    check("rand_err_cnt", 64'(err_cnt), 64'(mdl_cnt));

    // Overflow: limit holds the FIFO, six mismatching vectors, four fit.
    max_err = mdl_cnt;
    for (int i = 0; i < 6; i++) begin
      send_vec(32'd100 + 32'(i), 16'(1 << i), 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, i < 4);
    end
    idle();
    repeat (5) @(negedge clk);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_blocked_valid", 64'(err_valid), 64'd0);
    max_err = '0;
    drain();
    check("ovf_err_cnt", 64'(err_cnt), 64'(mdl_cnt));

    // Error limit of 3 with five single-bit mismatches, then last.
    do_reset();
    max_err = 32'd3;
    mdl_lim = 3;
    for (int i = 0; i < 5; i++) begin
      send_vec(32'd200 + 32'(i), 16'(1 << i), 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    end
    send_vec(32'd300, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    idle();
    begin
      int i = 0;
      while (!cmpdone && i < 500) begin
        @(negedge clk);
        i++;
      end
    end
    check("limit_cmpdone", 64'(cmpdone), 64'd1);
    check("limit_err_cnt", 64'(err_cnt), 64'd3);
    check("limit_pending", 64'(sb.size()), 64'd0);
    repeat (10) @(negedge clk);
    check("limit_done_valid", 64'(err_valid), 64'd0);
    max_err = '0;
    mdl_lim = 0;

    // Vector number wrap, then reset while a record is presented.
    do_reset();
    err_ready = 1'b0;
    send_vec(32'hFFFF_FFFF, 16'h0008, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    idle();
    wait_valid("wrap_valid");
    check("wrap_err_vec", 64'(err_vec), 64'd0);
    check("wrap_err_sig", 64'(err_sig), 64'h12);
    check("wrap_err_exp", 64'(err_exp), 64'd1);
    ureset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_err_valid", 64'(err_valid), 64'd0);
    check("midrst_err_vec", 64'(err_vec), 64'd0);
    check("midrst_err_sig", 64'(err_sig), 64'h0F);
    check("midrst_err_exp", 64'(err_exp), 64'd0);
    check("midrst_err_rcv", 64'(err_rcv), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_cmpdone", 64'(cmpdone), 64'd0);
    sb.delete();
    mdl_cnt = 0;
    @(negedge clk);
    ureset    = 1'b0;
    err_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_err_valid", 64'(err_valid), 64'd0);
    check("postrst_err_cnt", 64'(err_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
